int_stim_gen: RTL and testbench

Multi-channel, programmable interrupt stimulus generator for the P7 MIPS system bench and FPGA harness. It watches the CPU's macroscopic PC and the interrupt-acknowledge store bus. On a programmed PC match, plus an optional delay, it raises a per-channel interrupt and holds it until the CPU writes that channel's acknowledge address. It replaces the single hard-wired one-shot trigger with N independently armed channels that support repeat counts and delays.

---
 rtl/int_stim_gen.sv | 245 ++++++++++++++++++++++++
 tb/tb_int_stim_gen.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_stim_gen.sv
// int_stim_gen: N-channel PC-match interrupt stimulus generator with delay, repeat count and store-bus ack.
// Define INT_STIM_TIMEOUT_EN to build the per-channel ack timeout and sticky timeout_err flags.
module int_stim_gen #(
    parameter int          NUM_CH      = 6,
    parameter logic [31:0] ACK_BASE    = 32'h0000_7f20,
    parameter int          ACK_TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               macroscopic_pc,
    input  logic [31:0]               m_int_addr,
    input  logic [3:0]                m_int_byteen,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [1:0]                cfg_sel,
    input  logic [31:0]               cfg_wdata,
    output logic [NUM_CH-1:0]         interrupt,
    output logic                      int_any,
    output logic [15:0]               irq_count,
    output logic [NUM_CH-1:0]         timeout_err
);
    localparam int CH_W = $clog2(NUM_CH);
`ifdef INT_STIM_TIMEOUT_EN
    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
`endif

    if (ACK_TIMEOUT < 1) begin : g_bad_timeout
        $error("ACK_TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_DELAY  = 3'd2,
        ST_ASSERT = 3'd3,
        ST_DONE   = 3'd4
    } ch_state_t;

    logic [1:0]        rst_sync_r;
    logic              run_s;
    logic [31:0]       pc_word_s;
    logic [31:0]       ack_word_s;
    logic              store_s;
    logic [NUM_CH-1:0] enter_s;
    logic [NUM_CH-1:0] int_nxt_s;
    logic [NUM_CH-1:0] int_vec_s;
    logic              int_any_r;
    logic [15:0]       irq_count_r;
    logic [15:0]       irq_inc_s;
    logic [16:0]       irq_sum_s;
`ifdef INT_STIM_TIMEOUT_EN
    logic [NUM_CH-1:0] err_vec_s;
`endif

    // Reset release is re-timed through two flops; channels ignore configuration until it settles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign run_s      = rst_sync_r[1];
    assign pc_word_s  = macroscopic_pc & ~32'd3;
    assign ack_word_s = m_int_addr & ~32'd3;
    assign store_s    = (m_int_byteen != 4'd0);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [31:0] ACK_ADDR_C = ACK_BASE + 32'(4 * k);

        ch_state_t   state_r, state_s;
        logic [31:0] target_r, target_s;
        logic [15:0] delay_r, delay_s, dcnt_r, dcnt_s;
        logic [7:0]  shots_r, shots_s, left_r, left_s;
        logic        leave_r, leave_s;
        logic        int_r, int_s;
        logic        cfg_hit_s, ack_s, match_s;
`ifdef INT_STIM_TIMEOUT_EN
        logic [TO_W-1:0] tcnt_r, tcnt_s;
        logic            err_r, err_s;
`endif

        assign cfg_hit_s = run_s && cfg_we && (cfg_ch == CH_W'(k));
        assign ack_s     = store_s && (ack_word_s == (ACK_ADDR_C & ~32'd3));
        assign match_s   = (pc_word_s == target_r);

        // Channel next-state: a cfg write always takes priority over an ack in the same cycle.
        always_comb begin
            state_s  = state_r;
            target_s = target_r;
            delay_s  = delay_r;
            dcnt_s   = dcnt_r;
            shots_s  = shots_r;
            left_s   = left_r;
            leave_s  = leave_r;
            int_s    = int_r;
`ifdef INT_STIM_TIMEOUT_EN
            tcnt_s   = {TO_W{1'b0}};
            err_s    = err_r;
`endif
            if (cfg_hit_s) begin
                case (cfg_sel)
                    2'd0: target_s = cfg_wdata;
                    2'd1: delay_s  = cfg_wdata[15:0];
                    2'd2: shots_s  = cfg_wdata[7:0];
                    2'd3: begin
                        int_s = 1'b0;
                        if (cfg_wdata[0]) begin
                            state_s = ST_ARMED;
                            left_s  = shots_r;
                            leave_s = 1'b0;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end
                    default: state_s = state_r;
                endcase
            end else begin
                case (state_r)
                    ST_ARMED: begin
                        if (leave_r) begin
                            leave_s = match_s;
                        end else if (match_s) begin
                            if (delay_r == 16'd0) begin
                                state_s = ST_ASSERT;
                                int_s   = 1'b1;
                            end else begin
                                state_s = ST_DELAY;
                                dcnt_s  = delay_r;
                            end
                        end else begin
                            state_s = ST_ARMED;
                        end
                    end
                    ST_DELAY: begin
                        if (dcnt_r <= 16'd1) begin
                            state_s = ST_ASSERT;
                            int_s   = 1'b1;
                        end else begin
                            dcnt_s = dcnt_r - 16'd1;
                        end
                    end
                    ST_ASSERT: begin
                        if (ack_s) begin
                            int_s = 1'b0;
                            if ((shots_r == 8'd0) || (left_r > 8'd1)) begin
                                if (shots_r != 8'd0) begin
                                    left_s = left_r - 8'd1;
                                end else begin
                                    left_s = left_r;
                                end
                                leave_s = 1'b1;
                                state_s = ST_ARMED;
                            end else begin
                                state_s = ST_DONE;
                            end
`ifdef INT_STIM_TIMEOUT_EN
                        end else if (tcnt_r == TO_W'(ACK_TIMEOUT - 1)) begin
                            int_s   = 1'b0;
                            err_s   = 1'b1;
                            state_s = ST_DONE;
                        end else begin
                            tcnt_s = tcnt_r + {{(TO_W-1){1'b0}}, 1'b1};
                        end
`else
                        end else begin
                            state_s = ST_ASSERT;
                        end
`endif
                    end
                    default: state_s = state_r;
                endcase
            end
        end

        // Channel registers; reset clears everything including a held interrupt.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_r  <= ST_IDLE;
                target_r <= 32'd0;
                delay_r  <= 16'd0;
                dcnt_r   <= 16'd0;
                shots_r  <= 8'd0;
                left_r   <= 8'd0;
                leave_r  <= 1'b0;
                int_r    <= 1'b0;
`ifdef INT_STIM_TIMEOUT_EN
                tcnt_r   <= {TO_W{1'b0}};
                err_r    <= 1'b0;
`endif
            end else begin
                state_r  <= state_s;
                target_r <= target_s;
                delay_r  <= delay_s;
                dcnt_r   <= dcnt_s;
                shots_r  <= shots_s;
                left_r   <= left_s;
                leave_r  <= leave_s;
                int_r    <= int_s;
`ifdef INT_STIM_TIMEOUT_EN
                tcnt_r   <= tcnt_s;
                err_r    <= err_s;
`endif
            end
        end

        assign int_vec_s[k] = int_r;
        assign int_nxt_s[k] = int_s;
        assign enter_s[k]   = (state_s == ST_ASSERT) && (state_r != ST_ASSERT);
`ifdef INT_STIM_TIMEOUT_EN
        assign err_vec_s[k] = err_r;
`endif
    end

    // Count of channels entering ASSERT this cycle, added to the saturating total.
    always_comb begin
        irq_inc_s = 16'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            irq_inc_s = irq_inc_s + {15'd0, enter_s[i]};
        end
        irq_sum_s = {1'b0, irq_count_r} + {1'b0, irq_inc_s};
    end

    // Summary outputs share the channel register stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            int_any_r   <= 1'b0;
            irq_count_r <= 16'd0;
        end else begin
            int_any_r   <= |int_nxt_s;
            irq_count_r <= irq_sum_s[16] ? 16'hffff : irq_sum_s[15:0];
        end
    end

    assign interrupt = int_vec_s;
    assign int_any   = int_any_r;
    assign irq_count = irq_count_r;
`ifdef INT_STIM_TIMEOUT_EN
    assign timeout_err = err_vec_s;
`else
    assign timeout_err = {NUM_CH{1'b0}};
`endif

endmodule

// File: tb/tb_int_stim_gen.sv
// tb_int_stim_gen: directed scenarios plus randomized traffic against a behavioural channel model.
// Follows INT_STIM_TIMEOUT_EN the same way the design does.
module tb_int_stim_gen;
    localparam int          NCH   = 6;
    localparam int          TMO   = 16;
    localparam logic [31:0] ABASE = 32'h0000_7f20;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     macroscopic_pc;
    logic [31:0]     m_int_addr;
    logic [3:0]      m_int_byteen;
    logic            cfg_we;
    logic [2:0]      cfg_ch;
    logic [1:0]      cfg_sel;
    logic [31:0]     cfg_wdata;
    logic [NCH-1:0]  interrupt;
    logic            int_any;
    logic [15:0]     irq_count;
    logic [NCH-1:0]  timeout_err;

    int_stim_gen #(.NUM_CH(NCH), .ACK_BASE(ABASE), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .macroscopic_pc(macroscopic_pc),
        .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
        .interrupt(interrupt), .int_any(int_any), .irq_count(irq_count),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: per-channel flags and counters, not the design's states.
    logic [31:0] m_tgt [NCH];
    int          m_dly [NCH];
    int          m_shots [NCH];
    int          m_left [NCH];
    int          m_pend [NCH];
    int          m_held [NCH];
    bit          m_wait [NCH];
    bit          m_block [NCH];
    bit          m_irq [NCH];
    bit          m_err [NCH];
    int          m_count;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_tgt[c] = 32'd0; m_dly[c] = 0; m_shots[c] = 0; m_left[c] = 0;
            m_pend[c] = 0; m_held[c] = 0; m_wait[c] = 1'b0; m_block[c] = 1'b0;
            m_irq[c] = 1'b0; m_err[c] = 1'b0;
        end
        m_count = 0;
    endfunction

    function automatic void model_edge();
        logic [31:0] pcw;
        logic [31:0] ackw;
        int fired;
        pcw = macroscopic_pc & ~32'd3;
        ackw = m_int_addr & ~32'd3;
        fired = 0;
        for (int c = 0; c < NCH; c++) begin
            if (cfg_we && (int'(cfg_ch) == c)) begin
                case (cfg_sel)
                    2'd0: m_tgt[c] = cfg_wdata;
                    2'd1: m_dly[c] = int'(cfg_wdata[15:0]);
                    2'd2: m_shots[c] = int'(cfg_wdata[7:0]);
                    default: begin
                        m_pend[c] = 0; m_irq[c] = 1'b0; m_block[c] = 1'b0;
                        m_wait[c] = cfg_wdata[0]; m_left[c] = m_shots[c];
                    end
                endcase
            end else if (m_irq[c]) begin
                if ((m_int_byteen != 4'd0) && (ackw == ABASE + 32'(4 * c))) begin
                    m_irq[c] = 1'b0;
                    if ((m_shots[c] == 0) || (m_left[c] > 1)) begin
                        if (m_shots[c] != 0) m_left[c] = m_left[c] - 1;
                        m_block[c] = 1'b1;
                        m_wait[c] = 1'b1;
                    end
                end
`ifdef INT_STIM_TIMEOUT_EN
                else begin
                    m_held[c] = m_held[c] + 1;
                    if (m_held[c] == TMO) begin
                        m_irq[c] = 1'b0;
                        m_err[c] = 1'b1;
                    end
                end
`endif
            end else if (m_pend[c] > 0) begin
                m_pend[c] = m_pend[c] - 1;
                if (m_pend[c] == 0) begin
                    m_irq[c] = 1'b1; m_held[c] = 0; fired++;
                end
            end else if (m_wait[c]) begin
                if (m_block[c]) begin
                    if (pcw != m_tgt[c]) m_block[c] = 1'b0;
                end else if (pcw == m_tgt[c]) begin
                    m_wait[c] = 1'b0;
                    if (m_dly[c] == 0) begin
                        m_irq[c] = 1'b1; m_held[c] = 0; fired++;
                    end else begin
                        m_pend[c] = m_dly[c];
                    end
                end
            end
        end
        m_count = (m_count + fired > 65535) ? 65535 : m_count + fired;
    endfunction

    function automatic logic [NCH-1:0] exp_int();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_irq[c];
        return v;
    endfunction

    function automatic logic [NCH-1:0] exp_err();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_err[c];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        macroscopic_pc = 32'h0000_1000; m_int_addr = 32'd0; m_int_byteen = 4'd0;
        cfg_we = 1'b0; cfg_ch = 3'd0; cfg_sel = 2'd0; cfg_wdata = 32'd0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b1;
        repeat (4) step();
    endtask

    task automatic cfg_write(input int ch, input logic [1:0] sel, input logic [31:0] data);
        cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_sel = sel; cfg_wdata = data;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic arm_ch(input int ch, input logic [31:0] tgt, input int dly, input int shots);
        cfg_write(ch, 2'd0, tgt);
        cfg_write(ch, 2'd1, 32'(dly));
        cfg_write(ch, 2'd2, 32'(shots));
        cfg_write(ch, 2'd3, 32'd1);
    endtask

    task automatic ack(input logic [31:0] addr, input logic [3:0] be);
        m_int_addr = addr; m_int_byteen = be;
        step();
        m_int_byteen = 4'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        #2;
        n_cmp++; if (interrupt !== 6'b0) begin n_bad++; $display("FAIL reset_int: got %b want 000000", interrupt); end
        n_cmp++; if (int_any !== 1'b0) begin n_bad++; $display("FAIL reset_any: got %b want 0", int_any); end
        n_cmp++; if (irq_count !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", irq_count); end
        n_cmp++; if (timeout_err !== 6'b0) begin n_bad++; $display("FAIL reset_err: got %b want 000000", timeout_err); end
        apply_reset();
        n_cmp++; if (interrupt !== 6'b0) begin n_bad++; $display("FAIL reset_release_int: got %b want 000000", interrupt); end
    endtask

    task automatic test_single_shot();
        apply_reset();
        arm_ch(0, 32'h0000_3010, 0, 1);
        macroscopic_pc = 32'h0000_3010;
        step();
        n_cmp++; if (interrupt !== 6'b000001) begin n_bad++; $display("FAIL single_rise: got %b want 000001", interrupt); end
        n_cmp++; if (int_any !== 1'b1) begin n_bad++; $display("FAIL single_any: got %b want 1", int_any); end
        macroscopic_pc = 32'h0000_1000;
        ack(32'h0000_7f20, 4'b0001);
        n_cmp++; if (interrupt !== 6'b0) begin n_bad++; $display("FAIL single_ack: got %b want 000000", interrupt); end
        n_cmp++; if (int_any !== 1'b0) begin n_bad++; $display("FAIL single_any_drop: got %b want 0", int_any); end
        macroscopic_pc = 32'h0000_3012;
        repeat (3) step();
        n_cmp++; if (interrupt !== 6'b0) begin n_bad++; $display("FAIL single_no_reassert: got %b want 000000", interrupt); end
        n_cmp++; if (irq_count !== 16'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", irq_count); end
    endtask

    task automatic test_delay();
        apply_reset();
        arm_ch(2, 32'h0000_3020, 5, 1);
        macroscopic_pc = 32'h0000_3020;
        step();
        macroscopic_pc = 32'h0000_1000;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_cmp++; if (interrupt[2] !== 1'b0) begin n_bad++; $display("FAIL delay_early cycle %0d: got %b want 0", i + 1, interrupt[2]); end
        end
        step();
        n_cmp++; if (interrupt !== 6'b000100) begin n_bad++; $display("FAIL delay_rise: got %b want 000100", interrupt); end
        ack(32'h0000_7f20, 4'b1111);
        n_cmp++; if (interrupt !== 6'b000100) begin n_bad++; $display("FAIL delay_wrong_ack: got %b want 000100", interrupt); end
        ack(32'h0000_7f28, 4'b0010);
        n_cmp++; if (interrupt !== 6'b0) begin n_bad++; $display("FAIL delay_ack: got %b want 000000", interrupt); end
    endtask

    task automatic test_repeat();
        apply_reset();
        arm_ch(1, 32'h0000_3014, 0, 3);
        for (int it = 0; it < 5; it++) begin
            macroscopic_pc = 32'h0000_3014;
            step();
            n_cmp++; if (interrupt[1] !== (it < 3)) begin n_bad++; $display("FAIL repeat_fire %0d: got %b want %b", it, interrupt[1], it < 3); end
            ack(32'h0000_7f24, 4'b0100);
            step();
            n_cmp++; if (interrupt[1] !== 1'b0) begin n_bad++; $display("FAIL repeat_blocked %0d: got %b want 0", it, interrupt[1]); end
            macroscopic_pc = 32'h0000_2000;
            step();
        end
        n_cmp++; if (irq_count !== 16'd3) begin n_bad++; $display("FAIL repeat_count: got %0d want 3", irq_count); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        arm_ch(0, 32'h0000_3040, 0, 1);
        arm_ch(3, 32'h0000_3040, 0, 1);
        macroscopic_pc = 32'h0000_3041;
        step();
        n_cmp++; if (interrupt !== 6'b001001) begin n_bad++; $display("FAIL simul_rise: got %b want 001001", interrupt); end
        n_cmp++; if (irq_count !== 16'd2) begin n_bad++; $display("FAIL simul_count: got %0d want 2", irq_count); end
        macroscopic_pc = 32'h0000_1000;
        ack(32'h0000_7f2e, 4'b1000);
        n_cmp++; if (interrupt !== 6'b000001) begin n_bad++; $display("FAIL simul_ack3: got %b want 000001", interrupt); end
        ack(32'h0000_7f20, 4'b0001);
        n_cmp++; if (interrupt !== 6'b0) begin n_bad++; $display("FAIL simul_ack0: got %b want 000000", interrupt); end
    endtask

    task automatic test_timeout();
        apply_reset();
        arm_ch(0, 32'h0000_3010, 0, 1);
        macroscopic_pc = 32'h0000_3010;
        step();
        macroscopic_pc = 32'h0000_1000;
`ifdef INT_STIM_TIMEOUT_EN
        repeat (TMO - 1) step();
        n_cmp++; if (interrupt[0] !== 1'b1) begin n_bad++; $display("FAIL timeout_hold: got %b want 1", interrupt[0]); end
        step();
        n_cmp++; if (interrupt[0] !== 1'b0) begin n_bad++; $display("FAIL timeout_drop: got %b want 0", interrupt[0]); end
        n_cmp++; if (timeout_err !== 6'b000001) begin n_bad++; $display("FAIL timeout_err: got %b want 000001", timeout_err); end
        repeat (84) step();
        n_cmp++; if (timeout_err !== 6'b000001) begin n_bad++; $display("FAIL timeout_sticky: got %b want 000001", timeout_err); end
`else
        repeat (100) step();
        n_cmp++; if (interrupt[0] !== 1'b1) begin n_bad++; $display("FAIL notimeout_hold: got %b want 1", interrupt[0]); end
        n_cmp++; if (timeout_err !== 6'b0) begin n_bad++; $display("FAIL notimeout_err: got %b want 000000", timeout_err); end
`endif
    endtask

    task automatic test_reset_mid_delay();
        logic [NCH-1:0] seen;
        apply_reset();
        arm_ch(5, 32'h0000_3060, 0, 1);
        macroscopic_pc = 32'h0000_3060;
        step();
        n_cmp++; if (irq_count !== 16'd1) begin n_bad++; $display("FAIL midrst_pre_count: got %0d want 1", irq_count); end
        macroscopic_pc = 32'h0000_1000;
        arm_ch(4, 32'h0000_3050, 10, 1);
        macroscopic_pc = 32'h0000_3050;
        step();
        macroscopic_pc = 32'h0000_1000;
        repeat (3) step();
        n_cmp++; if (interrupt !== 6'b100000) begin n_bad++; $display("FAIL midrst_pre_int: got %b want 100000", interrupt); end
        #3 reset = 1'b0;
        #1;
        model_reset();
        n_cmp++; if (interrupt !== 6'b0) begin n_bad++; $display("FAIL midrst_int: got %b want 000000", interrupt); end
        n_cmp++; if (int_any !== 1'b0) begin n_bad++; $display("FAIL midrst_any: got %b want 0", int_any); end
        n_cmp++; if (irq_count !== 16'd0) begin n_bad++; $display("FAIL midrst_count: got %0d want 0", irq_count); end
        n_cmp++; if (timeout_err !== 6'b0) begin n_bad++; $display("FAIL midrst_err: got %b want 000000", timeout_err); end
        apply_reset();
        seen = 6'b0;
        for (int i = 0; i < 20; i++) begin
            macroscopic_pc = (i % 2 == 0) ? 32'h0000_3050 : 32'h0000_3060;
            step();
            seen = seen | interrupt;
        end
        n_cmp++; if (seen !== 6'b0) begin n_bad++; $display("FAIL midrst_stays_idle: got %b want 000000", seen); end
        macroscopic_pc = 32'h0000_1000;
        cfg_write(4, 2'd0, 32'h0000_3050);
        cfg_write(4, 2'd3, 32'd1);
        macroscopic_pc = 32'h0000_3050;
        step();
        n_cmp++; if (interrupt !== 6'b010000) begin n_bad++; $display("FAIL midrst_rearm: got %b want 010000", interrupt); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        apply_reset();
        for (int i = 0; i < 1500; i++) begin
            r = $urandom();
            macroscopic_pc = ($urandom_range(0, 5) == 0) ? 32'h0000_1000 : (32'h0000_3000 + 32'(4 * $urandom_range(0, 4)));
            macroscopic_pc = macroscopic_pc | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                m_int_addr = (ABASE + 32'(4 * $urandom_range(0, 7))) | 32'($urandom_range(0, 3));
                m_int_byteen = 4'($urandom_range(0, 15));
            end else begin
                m_int_byteen = 4'd0;
            end
            if ($urandom_range(0, 9) == 0) begin
                cfg_we = 1'b1;
                cfg_ch = 3'($urandom_range(0, 7));
                cfg_sel = 2'($urandom_range(0, 3));
                case (cfg_sel)
                    2'd0: cfg_wdata = 32'h0000_3000 + 32'(4 * $urandom_range(0, 3));
                    2'd1: cfg_wdata = {r[31:16], 16'($urandom_range(0, 3))};
                    2'd2: cfg_wdata = {r[31:8], 8'($urandom_range(0, 3))};
                    default: cfg_wdata = {r[31:1], ($urandom_range(0, 3) != 0)};
                endcase
            end else begin
                cfg_we = 1'b0;
            end
            step();
            n_cmp++; if (interrupt !== exp_int()) begin n_bad++; $display("FAIL rand_int cyc %0d: got %b want %b", i, interrupt, exp_int()); end
            n_cmp++; if (int_any !== (|exp_int())) begin n_bad++; $display("FAIL rand_any cyc %0d: got %b want %b", i, int_any, |exp_int()); end
            n_cmp++; if (irq_count !== 16'(m_count)) begin n_bad++; $display("FAIL rand_count cyc %0d: got %0d want %0d", i, irq_count, m_count); end
            n_cmp++; if (timeout_err !== exp_err()) begin n_bad++; $display("FAIL rand_err cyc %0d: got %b want %b", i, timeout_err, exp_err()); end
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_shot();
        test_delay();
        test_repeat();
        test_simultaneous();
        test_timeout();
        test_reset_mid_delay();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
